// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, owner codes,
// requester IDs and the winner-selection rule.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } arb_owner_e;

    localparam logic ARB_CPU = 1'b0;
    localparam logic ARB_LD  = 1'b1;

    // Lock beats every other rule once the loader already holds the RAM.
    function automatic logic pick_winner(
        input logic cpu_req,
        input logic ld_req,
        input logic lock_hold,
        input logic rr_mode,
        input logic rr_ptr,
        input logic starved
    );
        logic w;
        if (!ld_req) begin
            w = ARB_CPU;
        end else if (!cpu_req) begin
            w = ARB_LD;
        end else if (lock_hold) begin
            w = ARB_LD;
        end else if (rr_mode) begin
            w = rr_ptr;
        end else if (starved) begin
            w = ARB_LD;
        end else begin
            w = ARB_CPU;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_picker.sv
// Winner selection for the arbiter: round-robin pointer, loader starvation
// counter and the "loader served last" flag used by ld_lock.
module arb_picker
    import mem_arbiter_pkg::*;
#(
    parameter int RR_MODE    = 0,
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic ld_req,
    input  logic ld_lock,
    input  logic grant,
    output logic winner
);

    localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    logic          rr_ptr;
    logic          last_ld;
    logic [SW-1:0] starve_cnt;
    logic          starved;

    // Combinational winner from the current requests and registered history.
    always_comb begin
        starved = (starve_cnt >= STARVE_MAX);
        winner  = pick_winner(cpu_req, ld_req, ld_lock & last_ld,
                              (RR_MODE != 0), rr_ptr, starved);
    end

    // History update on each grant; the starve count saturates at its limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= ARB_CPU;
            last_ld    <= 1'b0;
            starve_cnt <= '0;
        end else if (grant) begin
            rr_ptr  <= ~winner;
            last_ld <= (winner == ARB_LD);
            if (winner == ARB_LD) begin
                starve_cnt <= '0;
            end else if (ld_req && !starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
                starve_cnt <= starve_cnt;
            end
        end else begin
            rr_ptr     <= rr_ptr;
            last_ld    <= last_ld;
            starve_cnt <= starve_cnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port RAM (CPU on port 0, loader/debug
// on port 1) with req/ack handshake, fixed read latency and CPU stall.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int RR_MODE    = 0,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              ld_lock,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    arb_state_e        state;
    arb_state_e        state_nxt;
    arb_owner_e        owner;
    logic [1:0]        wait_cnt;
    logic              wait_done;
    logic              grant;
    logic              winner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    assign grant     = (state == ARB_IDLE) && (cpu_req || ld_req);
    assign wait_done = (wait_cnt == WAIT_LAST);

    arb_picker #(
        .RR_MODE    (RR_MODE),
        .MAX_STARVE (MAX_STARVE)
    ) u_picker (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .ld_req  (ld_req),
        .ld_lock (ld_lock),
        .grant   (grant),
        .winner  (winner)
    );

    // Next-state logic; WAIT spans the RD_LAT cycles up to and including capture.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (grant) begin
                    state_nxt = ARB_ISSUE;
                end else begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_ISSUE: state_nxt = ARB_WAIT;
            ARB_WAIT: begin
                if (wait_done) begin
                    state_nxt = ARB_ACK;
                end else begin
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_ACK:  state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // State register, owner, latency counter and latched request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_NONE;
            wait_cnt  <= 2'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        owner     <= (winner == ARB_LD) ? OWN_LD : OWN_CPU;
                        lat_we    <= (winner == ARB_LD) ? ld_we    : cpu_we;
                        lat_addr  <= (winner == ARB_LD) ? ld_addr  : cpu_addr;
                        lat_wdata <= (winner == ARB_LD) ? ld_wdata : cpu_wdata;
                    end else begin
                        owner <= OWN_NONE;
                    end
                end
                ARB_ISSUE: wait_cnt <= 2'd0;
                ARB_WAIT:  wait_cnt <= wait_cnt + 2'd1;
                ARB_ACK:   owner    <= OWN_NONE;
                default:   owner    <= OWN_NONE;
            endcase
        end
    end

    // Read data capture into the owner's register on the last WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata <= '0;
            ld_rdata  <= '0;
        end else if ((state == ARB_WAIT) && wait_done && !lat_we) begin
            if (owner == OWN_LD) begin
                ld_rdata <= ram_rdata;
            end else begin
                cpu_rdata <= ram_rdata;
            end
        end else begin
            cpu_rdata <= cpu_rdata;
            ld_rdata  <= ld_rdata;
        end
    end

    assign ram_en    = (state == ARB_ISSUE);
    assign ram_we    = ram_en & lat_we;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign cpu_ack   = (state == ARB_ACK) && (owner == OWN_CPU);
    assign ld_ack    = (state == ARB_ACK) && (owner == OWN_LD);
    assign cpu_stall = cpu_req & ~((owner == OWN_CPU) & (state != ARB_IDLE));

endmodule
